// File: rtl/set_job_sched.sv
// Job scheduler for a SET engine: queues circle jobs, issues one at a time,
// and returns each result (or a timeout error) tagged with its job id.
module set_job_sched #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 400
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_central,
    input  logic [3:0]  req_radius,
    input  logic [3:0]  req_tag,
    output logic        eng_en,
    output logic [7:0]  eng_central,
    output logic [3:0]  eng_radius,
    input  logic        eng_busy,
    input  logic        eng_valid,
    input  logic [7:0]  eng_candidate,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [3:0]  res_tag,
    output logic [7:0]  res_count,
    output logic        res_err,
    output logic [15:0] stat_jobs
);

    localparam int         AW          = $clog2(FIFO_DEPTH);
    localparam logic [8:0] TIMEOUT_CNT = 9'(TIMEOUT);

    typedef struct packed {
        logic [3:0] tag;
        logic [3:0] radius;
        logic [7:0] central;
    } job_t;

    typedef enum logic [1:0] { IDLE, ISSUE, WAIT, HOLD } state_t;

    state_t      state, state_next;
    job_t        queue [FIFO_DEPTH];
    job_t        head;
    logic [AW:0] wr_ptr, rd_ptr;
    logic        push, pop, full, empty;
    logic [8:0]  wait_cnt, wait_cnt_inc;
    logic        timeout;
    logic [7:0]  last_central;
    logic [3:0]  last_radius;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign req_ready = !full;
    assign push      = req_valid && req_ready;
    assign pop       = (state == ISSUE);
    assign head      = queue[rd_ptr[AW-1:0]];

    // NOTE: the queue storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) queue[wr_ptr[AW-1:0]] <= {req_tag, req_radius, req_central};
    end

    // NOTE: registers are written with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // WAIT lasts exactly TIMEOUT cycles: the exit fires as the counter reaches TIMEOUT.
    assign wait_cnt_inc = wait_cnt + 9'd1;
    assign timeout      = (wait_cnt_inc == TIMEOUT_CNT);

    // NOTE: next-state is defaulted first so no path through the case can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!empty && !eng_busy) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (eng_valid || timeout) state_next = HOLD;
            HOLD:    if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt     <= '0;
            last_central <= '0;
            last_radius  <= '0;
            res_tag      <= '0;
            res_count    <= '0;
            res_err      <= 1'b0;
            stat_jobs    <= '0;
        end else begin
            case (state)
                ISSUE: begin
                    last_central <= head.central;
                    last_radius  <= head.radius;
                    res_tag      <= head.tag;
                    wait_cnt     <= '0;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt_inc;
                    // A result arriving on the final WAIT cycle beats the timeout.
                    if (eng_valid) begin
                        res_count <= eng_candidate;
                        res_err   <= 1'b0;
                    end else if (timeout) begin
                        res_count <= 8'hFF;
                        res_err   <= 1'b1;
                    end
                end
                HOLD: begin
                    if (res_ready && stat_jobs != 16'hFFFF) stat_jobs <= stat_jobs + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign eng_en      = (state == ISSUE);
    assign eng_central = eng_en ? head.central : last_central;
    assign eng_radius  = eng_en ? head.radius  : last_radius;
    assign res_valid   = (state == HOLD);

endmodule

// File: tb/tb_set_job_sched.sv
// Directed bench for set_job_sched with a programmable-latency engine stub
// whose result is stub_base + radius of the issued job.
module tb_set_job_sched;

    localparam int TIMEOUT = 400;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_central = '0;
    logic [3:0]  req_radius = '0;
    logic [3:0]  req_tag = '0;
    logic        eng_en;
    logic [7:0]  eng_central;
    logic [3:0]  eng_radius;
    logic        eng_busy = 1'b0;
    logic        eng_valid = 1'b0;
    logic [7:0]  eng_candidate = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [3:0]  res_tag;
    logic [7:0]  res_count;
    logic        res_err;
    logic [15:0] stat_jobs;

    int checks = 0;
    int failures = 0;

    // Engine stub state
    int         stub_lat = 0;
    int         stub_cnt = 0;
    logic [7:0] stub_base = '0;
    logic       stray = 1'b0;
    int         en_count = 0;
    logic [7:0] cap_central = '0;
    logic [3:0] cap_radius = '0;

    set_job_sched #(.FIFO_DEPTH(4), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_central(req_central), .req_radius(req_radius), .req_tag(req_tag),
        .eng_en(eng_en), .eng_central(eng_central), .eng_radius(eng_radius),
        .eng_busy(eng_busy), .eng_valid(eng_valid), .eng_candidate(eng_candidate),
        .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag),
        .res_count(res_count), .res_err(res_err), .stat_jobs(stat_jobs)
    );

    always #5 clk = ~clk;

    // Stub acts mid-cycle: counts ISSUE cycles, captures the job, and pulses
    // eng_valid on the stub_lat-th WAIT cycle (stub_lat = 0 means never).
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            stub_cnt  = 0;
            eng_valid = 1'b0;
        end else begin
            eng_valid = 1'b0;
            if (stray) begin
                eng_valid     = 1'b1;
                eng_candidate = 8'h77;
                stray         = 1'b0;
            end
            if (stub_cnt > 0) begin
                stub_cnt--;
                if (stub_cnt == 0) begin
                    eng_valid     = 1'b1;
                    eng_candidate = stub_base + {4'h0, cap_radius};
                end
            end
            if (eng_en) begin
                en_count++;
                cap_central = eng_central;
                cap_radius  = eng_radius;
                stub_cnt    = stub_lat;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] tag, input logic [7:0] central, input logic [3:0] radius);
        int n = 0;
        req_valid   = 1'b1;
        req_tag     = tag;
        req_central = central;
        req_radius  = radius;
        while (!req_ready && n < 100) begin
            tick();
            n++;
        end
        if (!req_ready) check("push_timeout", 0, 1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_en(input int budget);
        int n = 0;
        while (!eng_en && n < budget) begin
            tick();
            n++;
        end
        if (!eng_en) check("en_timeout", 0, 1);
    endtask

    task automatic wait_res(input int budget, output int cycles);
        cycles = 0;
        while (!res_valid && cycles < budget) begin
            tick();
            cycles++;
        end
        if (!res_valid) check("res_timeout", 0, 1);
    endtask

    task automatic accept();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int e0;
        int changes;
        int seen;
        logic [16:0] snap;

        // Reset state
        repeat (2) tick();
        check("rst_req_ready", req_ready, 1);
        check("rst_eng_en", eng_en, 0);
        check("rst_eng_central", eng_central, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_count", res_count, 0);
        check("rst_stat_jobs", stat_jobs, 0);
        rst = 1'b0;
        tick();

        // Single job: result 22 + 3 = 25, valid 4 samples after the ISSUE sample
        stub_base = 8'd22;
        stub_lat  = 3;
        e0 = en_count;
        push(4'd5, 8'h00, 4'd3);
        wait_en(10);
        check("t1_eng_central", eng_central, 8'h00);
        check("t1_eng_radius", eng_radius, 3);
        wait_res(20, lat);
        check("t1_latency", lat, 4);
        check("t1_en_pulses", en_count - e0, 1);
        check("t1_res_tag", res_tag, 5);
        check("t1_res_count", res_count, 25);
        check("t1_res_err", res_err, 0);
        check("t1_eng_radius_held", eng_radius, 3);
        accept();
        check("t1_res_valid_drop", res_valid, 0);
        check("t1_stat_jobs", stat_jobs, 1);

        // Zero radius
        stub_base = 8'd0;
        stub_lat  = 2;
        push(4'd2, 8'h11, 4'd0);
        wait_res(20, lat);
        check("t2_cap_central", cap_central, 8'h11);
        check("t2_res_tag", res_tag, 2);
        check("t2_res_count", res_count, 0);
        check("t2_res_err", res_err, 0);
        accept();
        check("t2_stat_jobs", stat_jobs, 2);

        // Stray eng_valid while idle is ignored
        e0 = en_count;
        stray = 1'b1;
        repeat (3) tick();
        check("stray_idle_res_valid", res_valid, 0);
        check("stray_idle_stat", stat_jobs, 2);
        check("stray_idle_en", en_count - e0, 0);

        // Back-pressure with busy gating
        stub_base = 8'h40;
        stub_lat  = 2;
        eng_busy  = 1'b1;
        e0 = en_count;
        for (int i = 1; i <= 4; i++) begin
            push(4'(i), {4'(i), 4'(i)}, 4'(i));
            check("bp_req_ready", req_ready, (i < 4) ? 1 : 0);
        end
        repeat (5) tick();
        check("busy_gate_no_en", en_count - e0, 0);
        eng_busy = 1'b0;
        tick();
        check("busy_issue_next", eng_en, 1);
        check("busy_issue_central", eng_central, 8'h11);
        push(4'd5, 8'h55, 4'd5);
        wait_res(20, lat);
        check("bp_first_tag", res_tag, 1);
        snap = {res_valid, res_tag, res_count, res_err, 3'b000};
        changes = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (k == 20) stray = 1'b1;
            if ({res_valid, res_tag, res_count, res_err, 3'b000} !== snap) changes++;
        end
        check("bp_hold_stable", changes, 0);
        check("bp_queue_full", req_ready, 0);
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_res(20, lat);
            check("bp_order_tag", res_tag, i + 1);
            check("bp_order_count", res_count, 8'h41 + 8'(i));
            check("bp_order_err", res_err, 0);
            tick();
            check("bp_idle_gap", {res_valid, eng_en}, 0);
            if (i < 4) begin
                tick();
                check("bp_reissue", eng_en, 1);
            end
        end
        res_ready = 1'b0;
        check("bp_stat_jobs", stat_jobs, 7);

        // Timeout: no eng_valid, HOLD exactly TIMEOUT cycles after WAIT entry
        stub_lat = 0;
        push(4'd9, 8'h22, 4'd4);
        wait_en(10);
        wait_res(TIMEOUT + 20, lat);
        check("to_latency", lat, TIMEOUT + 1);
        check("to_res_tag", res_tag, 9);
        check("to_res_count", res_count, 8'hFF);
        check("to_res_err", res_err, 1);
        accept();

        // eng_valid on the final WAIT cycle wins over the timeout
        stub_lat = TIMEOUT;
        push(4'd10, 8'h33, 4'd5);
        wait_en(10);
        wait_res(TIMEOUT + 20, lat);
        check("co_latency", lat, TIMEOUT + 1);
        check("co_res_count", res_count, 8'h45);
        check("co_res_err", res_err, 0);
        accept();
        check("co_stat_jobs", stat_jobs, 9);

        // Reset mid-WAIT with three jobs queued
        stub_lat = 0;
        e0 = en_count;
        for (int i = 12; i <= 15; i++) push(4'(i), 8'hC0 + 8'(i), 4'd2);
        repeat (10) tick();
        check("mr_one_issued", en_count - e0, 1);
        check("mr_queue_part", req_ready, 1);
        rst = 1'b1;
        #1;
        check("mr_eng_en", eng_en, 0);
        check("mr_eng_central", eng_central, 0);
        check("mr_eng_radius", eng_radius, 0);
        check("mr_res_valid", res_valid, 0);
        check("mr_res_tag", res_tag, 0);
        check("mr_res_count", res_count, 0);
        check("mr_res_err", res_err, 0);
        check("mr_stat_jobs", stat_jobs, 0);
        check("mr_req_ready", req_ready, 1);
        tick();
        rst = 1'b0;
        stub_lat = 3;
        e0 = en_count;
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (res_valid) seen++;
        end
        check("mr_no_result", seen, 0);
        check("mr_no_issue", en_count - e0, 0);
        check("mr_stat_after", stat_jobs, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
